// File: rtl/eeprom_boot_loader.sv
// eeprom_boot_loader
// Copies COUNT bytes from the asynchronous boot EEPROM into SRAM after reset,
// one byte every WAIT_CYCLES+2 cycles, then raises o_booted. While o_booted is
// low this block is the only driver of the EEPROM output enable and the SRAM
// write strobe. Every output is a flop.
//
// Per-byte cycle plan (cycle 0 = first clock edge with reset low):
//   READ    : WAIT_CYCLES cycles with n_oe low, data sampled on the edge that leaves READ
//   WRITE   : 1 cycle, n_we low, n_oe high, address/data stable
//   RECOVER : 1 cycle, n_we high, address/data held for SRAM hold time
module eeprom_boot_loader #(
    parameter int ADDR_WIDTH  = 17,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 3,
    parameter int COUNT       = 1 << 17
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_restart,
    output logic [ADDR_WIDTH-1:0] o_eeprom_addr,
    output logic                  o_eeprom_n_oe,
    input  logic [DATA_WIDTH-1:0] i_eeprom_data,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_n_we,
    output logic                  o_booted
);

    typedef enum logic [1:0] {
        S_READ,
        S_WRITE,
        S_RECOVER,
        S_DONE
    } state_t;

    // The index is one bit wider than the address so a full-size copy
    // (COUNT = 2^ADDR_WIDTH) can be compared without wrapping.
    localparam logic [ADDR_WIDTH:0] LAST_IDX  = (ADDR_WIDTH+1)'(COUNT - 1);
    localparam logic [3:0]          WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_idx;
    logic [3:0]            r_waitCnt;
    logic [ADDR_WIDTH:0]   w_nextIdx;

    assign w_nextIdx = r_idx + 1'b1;

    // Copy sequencer. Entering READ from reset finds n_oe still high, so that
    // first edge only lowers n_oe; the access-time count starts once n_oe is
    // actually low, which keeps the access time at WAIT_CYCLES for every byte.
    // RECOVER and RESTART lower n_oe directly when they re-enter READ.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_READ;
            r_idx         <= '0;
            r_waitCnt     <= '0;
            o_eeprom_n_oe <= 1'b1;
            o_ram_n_we    <= 1'b1;
            o_eeprom_addr <= '0;
            o_ram_addr    <= '0;
            o_ram_data    <= '0;
            o_booted      <= 1'b0;
        end else begin
            case (r_state)
                S_READ: begin
                    if (o_eeprom_n_oe) begin
                        o_eeprom_n_oe <= 1'b0;
                    end else if (r_waitCnt == WAIT_LAST) begin
                        o_ram_data    <= i_eeprom_data;
                        o_eeprom_n_oe <= 1'b1;
                        o_ram_n_we    <= 1'b0;
                        r_state       <= S_WRITE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 4'd1;
                    end
                end
                S_WRITE: begin
                    o_ram_n_we <= 1'b1;
                    r_state    <= S_RECOVER;
                end
                S_RECOVER: begin
                    if (r_idx == LAST_IDX) begin
                        o_booted <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx         <= w_nextIdx;
                        o_eeprom_addr <= w_nextIdx[ADDR_WIDTH-1:0];
                        o_ram_addr    <= w_nextIdx[ADDR_WIDTH-1:0];
                        r_waitCnt     <= '0;
                        o_eeprom_n_oe <= 1'b0;
                        r_state       <= S_READ;
                    end
                end
                S_DONE: begin
                    if (i_restart) begin
                        r_idx         <= '0;
                        o_eeprom_addr <= '0;
                        o_ram_addr    <= '0;
                        r_waitCnt     <= '0;
                        o_booted      <= 1'b0;
                        o_eeprom_n_oe <= 1'b0;
                        r_state       <= S_READ;
                    end
                end
                default: begin
                    r_state <= S_READ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_boot_loader.sv
// tb_eeprom_boot_loader
// Directed bench for the EEPROM boot loader. Three instances cover the
// parameter sets of interest: A (wait 3, 4 bytes), B (wait 1, 1 byte) and
// C (4-bit address, wait 2, 16 bytes). Each has an EEPROM model, an SRAM
// model and an invariant monitor.
module tb_eeprom_boot_loader;

    logic clock = 1'b0;
    int   assertCount = 0;
    int   failCount = 0;

    // Free-running clock shared by all instances
    always #5 clock = ~clock;

    // ---------------- instance A: WAIT 3, COUNT 4 ----------------
    logic       rstA = 1'b1, restartA = 1'b0, clrA = 1'b0;
    logic [7:0] eeAddrA, eeDataA, ramAddrA, ramDataA, eeBaseA;
    logic       nOeA, nWeA, bootedA;
    logic [7:0] memA [16];
    int         weCntA = 0, violA = 0;
    logic       prevWeA = 1'b1;

    assign eeDataA = nOeA ? 8'hFF : (eeBaseA + eeAddrA);

    eeprom_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_CYCLES(3), .COUNT(4)) dutA (
        .i_clk(clock), .i_rst(rstA), .i_restart(restartA),
        .o_eeprom_addr(eeAddrA), .o_eeprom_n_oe(nOeA), .i_eeprom_data(eeDataA),
        .o_ram_addr(ramAddrA), .o_ram_data(ramDataA), .o_ram_n_we(nWeA), .o_booted(bootedA)
    );

    // ---------------- instance B: WAIT 1, COUNT 1 ----------------
    logic       rstB = 1'b1, restartB = 1'b0, clrB = 1'b0;
    logic [3:0] eeAddrB, ramAddrB;
    logic [7:0] eeDataB, ramDataB;
    logic       nOeB, nWeB, bootedB;
    logic [7:0] memB [16];
    int         weCntB = 0, violB = 0;
    logic       prevWeB = 1'b1;

    assign eeDataB = nOeB ? 8'hFF : 8'h5A;

    eeprom_boot_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WAIT_CYCLES(1), .COUNT(1)) dutB (
        .i_clk(clock), .i_rst(rstB), .i_restart(restartB),
        .o_eeprom_addr(eeAddrB), .o_eeprom_n_oe(nOeB), .i_eeprom_data(eeDataB),
        .o_ram_addr(ramAddrB), .o_ram_data(ramDataB), .o_ram_n_we(nWeB), .o_booted(bootedB)
    );

    // ---------------- instance C: 4-bit address, WAIT 2, COUNT 16 ----------------
    logic       rstC = 1'b1, restartC = 1'b0, clrC = 1'b0;
    logic [3:0] eeAddrC, ramAddrC;
    logic [7:0] eeDataC, ramDataC;
    logic       nOeC, nWeC, bootedC;
    logic [7:0] memC [16];
    int         weCntC = 0, violC = 0;
    logic       prevWeC = 1'b1;

    assign eeDataC = nOeC ? 8'hFF : (8'h30 + {4'h0, eeAddrC});

    eeprom_boot_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WAIT_CYCLES(2), .COUNT(16)) dutC (
        .i_clk(clock), .i_rst(rstC), .i_restart(restartC),
        .o_eeprom_addr(eeAddrC), .o_eeprom_n_oe(nOeC), .i_eeprom_data(eeDataC),
        .o_ram_addr(ramAddrC), .o_ram_data(ramDataC), .o_ram_n_we(nWeC), .o_booted(bootedC)
    );

    // SRAM model and invariant monitor for A, sampled mid-cycle
    always @(negedge clock) begin
        if (clrA) begin
            for (int i = 0; i < 16; i++) memA[i] <= 8'h00;
            weCntA <= 0;
        end
        if (nWeA == 1'b0) begin
            memA[ramAddrA[3:0]] <= ramDataA;
            weCntA <= weCntA + 1;
        end
        violA <= violA + ((nWeA == 1'b0 && (bootedA || nOeA == 1'b0)) ? 1 : 0)
                       + ((nWeA == 1'b0 && prevWeA == 1'b0) ? 1 : 0);
        prevWeA <= nWeA;
    end

    // SRAM model and invariant monitor for B
    always @(negedge clock) begin
        if (clrB) begin
            for (int i = 0; i < 16; i++) memB[i] <= 8'h00;
            weCntB <= 0;
        end
        if (nWeB == 1'b0) begin
            memB[ramAddrB] <= ramDataB;
            weCntB <= weCntB + 1;
        end
        violB <= violB + ((nWeB == 1'b0 && (bootedB || nOeB == 1'b0)) ? 1 : 0)
                       + ((nWeB == 1'b0 && prevWeB == 1'b0) ? 1 : 0);
        prevWeB <= nWeB;
    end

    // SRAM model and invariant monitor for C
    always @(negedge clock) begin
        if (clrC) begin
            for (int i = 0; i < 16; i++) memC[i] <= 8'h00;
            weCntC <= 0;
        end
        if (nWeC == 1'b0) begin
            memC[ramAddrC] <= ramDataC;
            weCntC <= weCntC + 1;
        end
        violC <= violC + ((nWeC == 1'b0 && (bootedC || nOeC == 1'b0)) ? 1 : 0)
                       + ((nWeC == 1'b0 && prevWeC == 1'b0) ? 1 : 0);
        prevWeC <= nWeC;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic bootedOf(input int sel);
        case (sel)
            0:       return bootedA;
            1:       return bootedB;
            default: return bootedC;
        endcase
    endfunction

    // Drops reset (called just after a rising edge) and empties the SRAM model
    // before the next rising edge, which is cycle 0 of the copy.
    task automatic releaseReset(input int sel);
        case (sel)
            0: begin rstA = 1'b0; clrA = 1'b1; end
            1: begin rstB = 1'b0; clrB = 1'b1; end
            default: begin rstC = 1'b0; clrC = 1'b1; end
        endcase
        @(negedge clock);
        #1;
        clrA = 1'b0;
        clrB = 1'b0;
        clrC = 1'b0;
    endtask

    task automatic applyStimulus(input int sel);
        case (sel)
            0: rstA = 1'b1;
            1: rstB = 1'b1;
            default: rstC = 1'b1;
        endcase
        @(posedge clock);
        #1;
        releaseReset(sel);
    endtask

    // Counts cycles until booted is seen; the first edge waited on is cycle
    // startK. Optionally pulses RESTART on A for one cycle after edge pulseAt.
    task automatic waitBooted(input int sel, input int startK, input int pulseAt,
                              input int maxK, output int cyc);
        cyc = -1;
        for (int k = startK; k <= maxK; k++) begin
            @(posedge clock);
            #1;
            restartA = (k == pulseAt);
            if (bootedOf(sel)) begin
                cyc = k;
                break;
            end
        end
        restartA = 1'b0;
    endtask

    task automatic checkMemA(input string tag, input logic [7:0] base);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("%s sram[%0d]", tag, i), {24'h0, memA[i]}, {24'h0, base + 8'(i)});
    endtask

    initial begin
        int cyc;
        logic found;

        eeBaseA = 8'hA0;
        repeat (2) @(posedge clock);
        #1;

        // Reset values while reset is held
        checkOutput("rst n_oe", {31'h0, nOeA}, 32'h1);
        checkOutput("rst n_we", {31'h0, nWeA}, 32'h1);
        checkOutput("rst addr", {24'h0, eeAddrA}, 32'h0);
        checkOutput("rst data", {24'h0, ramDataA}, 32'h0);
        checkOutput("rst booted", {31'h0, bootedA}, 32'h0);

        // Scenario 1: four bytes, wait 3 -> booted at cycle 4*5
        releaseReset(0);
        waitBooted(0, 0, -1, 200, cyc);
        checkOutput("s1 boot cycle", cyc, 20);
        checkMemA("s1", 8'hA0);
        checkOutput("s1 we pulses", weCntA, 4);
        checkOutput("s1 final addr", {24'h0, ramAddrA}, 32'h3);
        checkOutput("s1 done n_oe", {31'h0, nOeA}, 32'h1);

        // Scenario 2: single byte, wait 1
        releaseReset(1);
        @(posedge clock); #1;
        checkOutput("s2 c0 n_oe", {31'h0, nOeB}, 32'h0);
        checkOutput("s2 c0 n_we", {31'h0, nWeB}, 32'h1);
        @(posedge clock); #1;
        checkOutput("s2 c1 n_we", {31'h0, nWeB}, 32'h0);
        checkOutput("s2 c1 n_oe", {31'h0, nOeB}, 32'h1);
        @(posedge clock); #1;
        checkOutput("s2 c2 n_we", {31'h0, nWeB}, 32'h1);
        checkOutput("s2 c2 booted", {31'h0, bootedB}, 32'h0);
        @(posedge clock); #1;
        checkOutput("s2 c3 booted", {31'h0, bootedB}, 32'h1);
        checkOutput("s2 sram[0]", {24'h0, memB[0]}, 32'h5A);
        checkOutput("s2 we pulses", weCntB, 1);

        // Scenario 4: new EEPROM image, RESTART from DONE
        eeBaseA = 8'h11;
        clrA = 1'b1;
        @(negedge clock); #1;
        clrA = 1'b0;
        @(posedge clock); #1;
        restartA = 1'b1;
        @(posedge clock); #1;
        restartA = 1'b0;
        checkOutput("s4 booted drop", {31'h0, bootedA}, 32'h0);
        waitBooted(0, 1, -1, 200, cyc);
        checkOutput("s4 boot cycle", cyc, 20);
        checkMemA("s4", 8'h11);
        checkOutput("s4 we pulses", weCntA, 4);

        // Scenario 5: RESTART during READ of byte 1 is ignored
        eeBaseA = 8'hA0;
        applyStimulus(0);
        waitBooted(0, 0, 5, 200, cyc);
        checkOutput("s5 boot cycle", cyc, 20);
        checkMemA("s5", 8'hA0);
        checkOutput("s5 we pulses", weCntA, 4);

        // Scenario 3: reset during the WRITE of byte 2
        applyStimulus(0);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock); #1;
            if (nWeA == 1'b0 && ramAddrA == 8'h02) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("s3 write2 seen", {31'h0, found}, 32'h1);
        rstA = 1'b1;
        @(posedge clock); #1;
        checkOutput("s3 n_we abort", {31'h0, nWeA}, 32'h1);
        checkOutput("s3 addr reset", {24'h0, eeAddrA}, 32'h0);
        checkOutput("s3 n_oe reset", {31'h0, nOeA}, 32'h1);
        releaseReset(0);
        waitBooted(0, 0, -1, 200, cyc);
        checkOutput("s3 boot cycle", cyc, 20);
        checkMemA("s3", 8'hA0);
        checkOutput("s3 we pulses", weCntA, 4);

        // Scenario 6: full 4-bit address space, wait 2 -> 16*4 cycles
        releaseReset(2);
        waitBooted(2, 0, -1, 300, cyc);
        checkOutput("s6 boot cycle", cyc, 64);
        checkOutput("s6 last addr", {28'h0, ramAddrC}, 32'hF);
        checkOutput("s6 ee addr", {28'h0, eeAddrC}, 32'hF);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("s6 sram[%0d]", i), {24'h0, memC[i]}, {24'h0, 8'h30 + 8'(i)});
        checkOutput("s6 we pulses", weCntC, 16);

        // Invariants held throughout every scenario
        @(posedge clock); #1;
        checkOutput("inv A", violA, 0);
        checkOutput("inv B", violB, 0);
        checkOutput("inv C", violC, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
